// File: rtl/coax_tx_pkg.sv
// Shared coax link definitions: frame sequence lengths, word width and parity.
// The receive side uses the same values so both ends agree on framing.
package coax_tx_pkg;

   localparam int WORD_W            = 10;
   localparam int START_ONES        = 5;   // '1' bits opening a frame
   localparam int START_LOW_HALVES  = 3;
   localparam int START_HIGH_HALVES = 3;
   localparam int END_HIGH_HALVES   = 4;
   localparam int START_HALVES      = 2*START_ONES + START_LOW_HALVES + START_HIGH_HALVES;
   localparam int END_HALVES        = 2 + END_HIGH_HALVES;
   localparam int HCW               = 4;   // half-bit counter width, covers START_HALVES-1

   // Even parity across sync + data + parity; the sync bit is always 1.
   function automatic logic coax_parity(input logic [WORD_W-1:0] w);
      return ~^w;
   endfunction

endpackage

// File: rtl/coax_tx_bit_timer.sv
// Bit-time counter for the transmitter; held at zero while the link is idle
// so every frame starts on a clean bit boundary.
module coax_tx_bit_timer #(
   parameter int CLOCKS_PER_BIT = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic first_half,
   output logic mid_bit,
   output logic end_bit
);

   localparam int HALF = CLOCKS_PER_BIT / 2;
   localparam int CW   = $clog2(CLOCKS_PER_BIT);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clear)
         cnt <= '0;
      else if (cnt == CW'(CLOCKS_PER_BIT-1))
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign first_half = (cnt < CW'(HALF));
   assign mid_bit    = (cnt == CW'(HALF-1));
   assign end_bit    = (cnt == CW'(CLOCKS_PER_BIT-1));

endmodule

// File: rtl/coax_tx.sv
// 3270 coax transmitter: bi-phase encodes framed 10-bit words onto tx.
// tx and active are registered, so both lag the state machine by one clock.
module coax_tx
   import coax_tx_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [WORD_W-1:0] data,
   input  logic              strobe,
   output logic              ready,
   output logic              tx,
   output logic              active
);

   typedef enum logic [2:0] {
      IDLE, START_SEQUENCE, SYNC_BIT, DATA_BIT, PARITY_BIT, END_SEQUENCE
   } state_t;

   state_t            state, state_nxt;
   logic [HCW-1:0]    hcnt, hcnt_nxt;
   logic [3:0]        bit_cnt, bit_cnt_nxt;
   logic [WORD_W-1:0] shift, shift_nxt, hold, hold_nxt;
   logic              hold_full, hold_full_nxt;
   logic              tx_nxt, active_nxt, accept, load_word;
   logic              first_half, mid_bit, end_bit;

   coax_tx_bit_timer #(.CLOCKS_PER_BIT(CLOCKS_PER_BIT)) u_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (state == IDLE),
      .first_half(first_half),
      .mid_bit   (mid_bit),
      .end_bit   (end_bit)
   );

   assign ready  = ~hold_full;
   assign accept = strobe & ~hold_full;

   always_comb begin
      state_nxt     = state;
      bit_cnt_nxt   = bit_cnt;
      shift_nxt     = shift;
      hold_nxt      = hold;
      hold_full_nxt = hold_full;
      tx_nxt        = 1'b0;
      load_word     = 1'b0;
      if (accept) begin
         hold_nxt      = data;
         hold_full_nxt = 1'b1;
      end
      case (state)
         IDLE:
            if (hold_full) state_nxt = START_SEQUENCE;
         START_SEQUENCE: begin
            if (hcnt < HCW'(2*START_ONES))
               tx_nxt = hcnt[0];
            else
               tx_nxt = (hcnt >= HCW'(2*START_ONES + START_LOW_HALVES));
            if (end_bit && hcnt == HCW'(START_HALVES-1)) load_word = 1'b1;
         end
         SYNC_BIT: begin
            tx_nxt = ~first_half;
            if (end_bit) begin
               state_nxt   = DATA_BIT;
               bit_cnt_nxt = 4'(WORD_W-1);
            end
         end
         DATA_BIT: begin
            tx_nxt = shift[bit_cnt] ^ first_half;
            if (end_bit) begin
               if (bit_cnt == 4'd0) state_nxt = PARITY_BIT;
               else                 bit_cnt_nxt = bit_cnt - 4'd1;
            end
         end
         PARITY_BIT: begin
            tx_nxt = coax_parity(shift) ^ first_half;
            // A word strobed on the very last parity cycle still goes back-to-back.
            if (end_bit) begin
               if (hold_full || accept) load_word = 1'b1;
               else                     state_nxt = END_SEQUENCE;
            end
         end
         END_SEQUENCE: begin
            tx_nxt = (hcnt != HCW'(1));
            if (end_bit && hcnt == HCW'(END_HALVES-1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (load_word) begin
         state_nxt     = SYNC_BIT;
         hold_full_nxt = 1'b0;
         shift_nxt     = hold_full ? hold : data;
      end
      hcnt_nxt   = (state_nxt != state) ? '0 : hcnt + HCW'(mid_bit | end_bit);
      active_nxt = (state != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         hcnt      <= '0;
         bit_cnt   <= '0;
         shift     <= '0;
         hold      <= '0;
         hold_full <= 1'b0;
         tx        <= 1'b0;
         active    <= 1'b0;
      end else begin
         state     <= state_nxt;
         hcnt      <= hcnt_nxt;
         bit_cnt   <= bit_cnt_nxt;
         shift     <= shift_nxt;
         hold      <= hold_nxt;
         hold_full <= hold_full_nxt;
         tx        <= tx_nxt;
         active    <= active_nxt;
      end
   end

endmodule

// File: tb/tb_coax_tx.sv
// Directed bench for coax_tx: expected line waveforms are written out half-bit
// by half-bit and compared every clock on the falling edge.
module tb_coax_tx;

   localparam int CPB  = 8;
   localparam int HALF = CPB / 2;

   logic       clk = 1'b0;
   logic       reset, strobe;
   logic [9:0] data;
   logic       ready, tx, active;

   int   n_assert = 0;
   int   n_fail   = 0;
   logic exp_q[$];

   coax_tx #(.CLOCKS_PER_BIT(CPB)) dut (
      .clk   (clk),
      .reset (reset),
      .data  (data),
      .strobe(strobe),
      .ready (ready),
      .tx    (tx),
      .active(active)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic obs, input logic exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic add_half(input logic v);
      repeat (HALF) exp_q.push_back(v);
   endtask

   task automatic add_bit(input logic b);
      add_half(~b);
      add_half(b);
   endtask

   task automatic add_start();
      repeat (5) add_bit(1'b1);
      repeat (3) add_half(1'b0);
      repeat (3) add_half(1'b1);
   endtask

   task automatic add_word(input logic [9:0] w, input logic p);
      add_bit(1'b1);
      for (int i = 9; i >= 0; i--) add_bit(w[i]);
      add_bit(p);
   endtask

   task automatic add_end();
      add_half(1'b1);
      add_half(1'b0);
      repeat (4) add_half(1'b1);
   endtask

   // Strobe one word from idle; returns one cycle before active rises.
   task automatic send(input logic [9:0] d);
      @(negedge clk);
      data   = d;
      strobe = 1'b1;
      @(negedge clk);
      strobe = 1'b0;
      chk("ready_after_load", ready, 1'b0);
      @(negedge clk);
      chk("active_before_start", active, 1'b0);
   endtask

   // Compare n cycles of the expected frame; optionally strobe at two indices.
   task automatic run_frame(input int n, input int inj_a, input logic [9:0] da,
                            input int inj_b, input logic [9:0] db);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk($sformatf("tx[%0d]", i), tx, exp_q[i]);
         chk($sformatf("active[%0d]", i), active, 1'b1);
         if (i == 62) chk("ready_before_sync", ready, 1'b0);
         if (i == 63) chk("ready_at_sync", ready, 1'b1);
         strobe = (i == inj_a) || (i == inj_b);
         data   = (i == inj_b) ? db : da;
      end
      strobe = 1'b0;
   endtask

   task automatic chk_idle(input string tag, input int cycles, input logic exp_ready);
      repeat (cycles) begin
         @(negedge clk);
         chk({tag, "_tx"}, tx, 1'b0);
         chk({tag, "_active"}, active, 1'b0);
         chk({tag, "_ready"}, ready, exp_ready);
      end
   endtask

   initial begin
      // Reset with strobe held high: strobe must be ignored.
      reset  = 1'b1;
      strobe = 1'b1;
      data   = 10'h3FF;
      chk_idle("reset", 8, 1'b1);
      reset  = 1'b0;
      strobe = 1'b0;
      chk_idle("post_reset", 3, 1'b1);

      // Single word, parity 1.
      exp_q.delete();
      add_start(); add_word(10'b0110110011, 1'b1); add_end();
      send(10'b0110110011);
      run_frame(exp_q.size(), -1, 10'h0, -1, 10'h0);
      chk_idle("single_end", 4, 1'b1);

      // Single word, parity 0.
      exp_q.delete();
      add_start(); add_word(10'b0000000001, 1'b0); add_end();
      send(10'b0000000001);
      run_frame(exp_q.size(), -1, 10'h0, -1, 10'h0);
      chk_idle("par0_end", 4, 1'b1);

      // Back-to-back: second word during first's data, third strobe dropped.
      exp_q.delete();
      add_start(); add_word(10'b1011001110, 1'b1); add_word(10'b1110000000, 1'b0); add_end();
      send(10'b1011001110);
      run_frame(exp_q.size(), 80, 10'b1110000000, 100, 10'h155);
      chk_idle("b2b_end", 10, 1'b1);

      // Reset during data bit 5 (tx high at that point), strobe ignored in reset.
      exp_q.delete();
      add_start(); add_word(10'b1001011010, 1'b0); add_end();
      send(10'b1001011010);
      run_frame(106, -1, 10'h0, -1, 10'h0);
      reset  = 1'b1;
      strobe = 1'b1;
      data   = 10'h3FF;
      chk_idle("mid_reset", 1, 1'b1);
      reset  = 1'b0;
      strobe = 1'b0;
      chk_idle("after_reset", 2, 1'b1);
      exp_q.delete();
      add_start(); add_word(10'b0101010101, 1'b0); add_end();
      send(10'b0101010101);
      run_frame(exp_q.size(), -1, 10'h0, -1, 10'h0);
      chk_idle("fresh_end", 4, 1'b1);

      // Strobe during end sequence: one idle cycle, then held word's frame.
      exp_q.delete();
      add_start(); add_word(10'b0110110011, 1'b1); add_end();
      send(10'b0110110011);
      run_frame(exp_q.size(), 165, 10'b1100000011, -1, 10'h0);
      chk_idle("gap", 1, 1'b0);
      exp_q.delete();
      add_start(); add_word(10'b1100000011, 1'b1); add_end();
      run_frame(exp_q.size(), -1, 10'h0, -1, 10'h0);
      chk_idle("held_end", 4, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
